// File: rtl/conv_pipe_sequencer.sv
// conv_pipe_sequencer: per-pixel conv -> finish -> drain -> (optional 1x1 stage) layer sequencer.
// Define CONV_PIPE_SEQ_PW_EN to include the PW (1x1 pointwise) stage.
module conv_pipe_sequencer #(
    parameter int              NUM_PIXELS = 2916,
    parameter longint unsigned BUF_DEPTH  = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        done_window,
    output logic        cal_start,
    output logic [15:0] PE_reset,
    output logic [15:0] PE_finish,
    output logic [1:0]  control_mux,
    output logic        wr_en_next,
    output logic [31:0] addr_ram_next_wr,
    output logic [31:0] addr_ram_next_rd,
    output logic [31:0] addr_w_n_state,
    output logic [3:0]  PE_reset_n_state,
    output logic        busy,
    output logic        done,
    output logic        overrun
);
    typedef enum logic [2:0] {IDLE, CONV, FIN, DRAIN, PW, DONE} state_t;
    localparam logic [31:0] PTR_LAST = 32'(BUF_DEPTH - 1);
    localparam logic [31:0] PIX_LAST = 32'(NUM_PIXELS - 1);

    state_t      state, state_nx;
    logic [2:0]  phase;
    logic [31:0] wr_ptr, wr_hold, pixel_cnt;
    logic        accept, drain, stage_end;

    assign accept = state == IDLE && start;
    assign drain  = state == DRAIN;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            phase     <= '0;
            wr_ptr    <= '0;
            wr_hold   <= '0;
            pixel_cnt <= '0;
            overrun   <= 1'b0;
        end else begin
            state <= state_nx;
            phase <= (state_nx == state) ? phase + 3'd1 : 3'd0;
            if (accept) begin
                wr_ptr    <= '0;
                pixel_cnt <= '0;
            end
            if (drain) begin
                wr_ptr  <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 32'd1;
                wr_hold <= wr_ptr;
            end
            if (stage_end) pixel_cnt <= pixel_cnt + 32'd1;
            overrun <= (overrun && !accept) || (done_window && state != CONV);
        end
    end

`ifdef CONV_PIPE_SEQ_PW_EN
    logic [31:0] rd_ptr, rd_hold;
    logic [1:0]  w_hold;
    logic        rd_act;

    // j=4 is the BRAM read-latency slot: no new read issued
    assign rd_act    = state == PW && !phase[2];
    assign stage_end = state == PW && phase == 3'd4;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr  <= '0;
            rd_hold <= '0;
            w_hold  <= '0;
        end else begin
            if (accept) rd_ptr <= '0;
            if (rd_act) begin
                rd_ptr  <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 32'd1;
                rd_hold <= rd_ptr;
                w_hold  <= phase[1:0];
            end
        end
    end

    assign addr_ram_next_rd = rd_act ? rd_ptr : rd_hold;
    assign addr_w_n_state   = {30'd0, rd_act ? phase[1:0] : w_hold};
    assign PE_reset_n_state = {4{state == PW && phase == 3'd0}};
`else
    assign stage_end        = drain && phase == 3'd3;
    assign addr_ram_next_rd = '0;
    assign addr_w_n_state   = '0;
    assign PE_reset_n_state = '0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CONV;
            CONV:    if (done_window) state_nx = FIN;
            FIN:     state_nx = DRAIN;
            DONE:    state_nx = IDLE;
            default: ;
        endcase
`ifdef CONV_PIPE_SEQ_PW_EN
        if (drain && phase == 3'd3) state_nx = PW;
`endif
        if (stage_end) state_nx = (pixel_cnt == PIX_LAST) ? DONE : CONV;
    end

    always_comb begin
        cal_start        = state == CONV;
        busy             = state != IDLE;
        done             = state == DONE;
        wr_en_next       = drain;
        control_mux      = drain ? phase[1:0] : 2'd0;
        PE_finish        = {16{state == FIN}};
        PE_reset         = {16{drain && phase == 3'd0}};
        addr_ram_next_wr = drain ? wr_ptr : wr_hold;
    end
endmodule

// File: tb/tb_conv_pipe_sequencer.sv
// tb_conv_pipe_sequencer: directed, table-driven check of two sequencer instances (64- and 8-deep buffers).
module tb_conv_pipe_sequencer;
`ifdef CONV_PIPE_SEQ_PW_EN
    localparam int LAT = 11;
`else
    localparam int LAT = 6;
`endif
    logic clk = 0, reset_n = 0, start = 0, done_window = 0;
    always #5 clk = ~clk;

    logic        cal_a, wen_a, busy_a, done_a, ovr_a, cal_b, wen_b, busy_b, done_b, ovr_b;
    logic [15:0] rst_a, fin_a, rst_b, fin_b;
    logic [1:0]  mux_a, mux_b;
    logic [31:0] wr_a, rd_a, wn_a, wr_b, rd_b, wn_b;
    logic [3:0]  prn_a, prn_b;

    conv_pipe_sequencer #(.NUM_PIXELS(3), .BUF_DEPTH(64)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .done_window(done_window),
        .cal_start(cal_a), .PE_reset(rst_a), .PE_finish(fin_a), .control_mux(mux_a),
        .wr_en_next(wen_a), .addr_ram_next_wr(wr_a), .addr_ram_next_rd(rd_a),
        .addr_w_n_state(wn_a), .PE_reset_n_state(prn_a), .busy(busy_a), .done(done_a),
        .overrun(ovr_a));
    conv_pipe_sequencer #(.NUM_PIXELS(3), .BUF_DEPTH(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .done_window(done_window),
        .cal_start(cal_b), .PE_reset(rst_b), .PE_finish(fin_b), .control_mux(mux_b),
        .wr_en_next(wen_b), .addr_ram_next_wr(wr_b), .addr_ram_next_rd(rd_b),
        .addr_w_n_state(wn_b), .PE_reset_n_state(prn_b), .busy(busy_b), .done(done_b),
        .overrun(ovr_b));

    typedef struct {
        int          conv_cycles;
        bit          start_in_conv;
        bit          dw_in_drain;
        logic [31:0] base_a;
        logic [31:0] base_b;
    } px_t;

    int n_chk = 0, n_fail = 0, cyc_n = 0;
    logic [31:0] hw_a = 0, hw_b = 0, hr_a = 0, hr_b = 0, hwn = 0;
    logic ovr = 0;
    always @(posedge clk) cyc_n++;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", n, act, exp);
        end
    endtask

    task automatic cyc(input string t, input logic cal, fin, rst, input logic [1:0] mux,
                       input logic wen, input logic [31:0] wa, wb, ra, rb, wn,
                       input logic [3:0] prn, input logic bz, dn);
        chk({t, ".cal_a"}, 32'(cal_a), 32'(cal));          chk({t, ".cal_b"}, 32'(cal_b), 32'(cal));
        chk({t, ".fin_a"}, 32'(fin_a), 32'({16{fin}}));    chk({t, ".fin_b"}, 32'(fin_b), 32'({16{fin}}));
        chk({t, ".rst_a"}, 32'(rst_a), 32'({16{rst}}));    chk({t, ".rst_b"}, 32'(rst_b), 32'({16{rst}}));
        chk({t, ".mux_a"}, 32'(mux_a), 32'(mux));          chk({t, ".mux_b"}, 32'(mux_b), 32'(mux));
        chk({t, ".wen_a"}, 32'(wen_a), 32'(wen));          chk({t, ".wen_b"}, 32'(wen_b), 32'(wen));
        chk({t, ".wr_a"}, wr_a, wa);                       chk({t, ".wr_b"}, wr_b, wb);
        chk({t, ".rd_a"}, rd_a, ra);                       chk({t, ".rd_b"}, rd_b, rb);
        chk({t, ".wn_a"}, wn_a, wn);                       chk({t, ".wn_b"}, wn_b, wn);
        chk({t, ".prn_a"}, 32'(prn_a), 32'(prn));          chk({t, ".prn_b"}, 32'(prn_b), 32'(prn));
        chk({t, ".busy_a"}, 32'(busy_a), 32'(bz));         chk({t, ".busy_b"}, 32'(busy_b), 32'(bz));
        chk({t, ".done_a"}, 32'(done_a), 32'(dn));         chk({t, ".done_b"}, 32'(done_b), 32'(dn));
        chk({t, ".ovr_a"}, 32'(ovr_a), 32'(ovr));          chk({t, ".ovr_b"}, 32'(ovr_b), 32'(ovr));
    endtask

    task automatic idle_chk(input string t);
        cyc(t, 0, 0, 0, 0, 0, hw_a, hw_b, hr_a, hr_b, hwn, 0, 0, 0);
    endtask

    // Entered in CONV; leaves in CONV (more pixels) or IDLE (after the done pulse).
    task automatic run_pixel(input px_t p, input bit last);
        int t0;
        for (int c = 0; c < p.conv_cycles; c++) begin
            cyc("conv", 1, 0, 0, 0, 0, hw_a, hw_b, hr_a, hr_b, hwn, 0, 1, 0);
            start = p.start_in_conv;
            step;
            start = 0;
        end
        cyc("conv_dw", 1, 0, 0, 0, 0, hw_a, hw_b, hr_a, hr_b, hwn, 0, 1, 0);
        done_window = 1;
        t0 = cyc_n;
        step;
        done_window = 0;
        cyc("fin", 0, 1, 0, 0, 0, hw_a, hw_b, hr_a, hr_b, hwn, 0, 1, 0);
        step;
        for (int k = 0; k < 4; k++) begin
            cyc($sformatf("drain%0d", k), 0, 0, k == 0, 2'(k), 1, p.base_a + k, p.base_b + k,
                hr_a, hr_b, hwn, 0, 1, 0);
            done_window = p.dw_in_drain && k == 1;
            step;
            if (done_window) ovr = 1;
            done_window = 0;
        end
        hw_a = p.base_a + 3;
        hw_b = p.base_b + 3;
`ifdef CONV_PIPE_SEQ_PW_EN
        for (int j = 0; j < 4; j++) begin
            cyc($sformatf("pw%0d", j), 0, 0, 0, 0, 0, hw_a, hw_b, p.base_a + j, p.base_b + j,
                j, (j == 0) ? 4'hF : 4'h0, 1, 0);
            step;
        end
        hr_a = p.base_a + 3;
        hr_b = p.base_b + 3;
        hwn  = 3;
        cyc("pw4", 0, 0, 0, 0, 0, hw_a, hw_b, hr_a, hr_b, hwn, 0, 1, 0);
        step;
`endif
        if (last) begin
            cyc("done", 0, 0, 0, 0, 0, hw_a, hw_b, hr_a, hr_b, hwn, 0, 1, 1);
            chk("latency", cyc_n - t0, LAT);
            step;
            idle_chk("after_done");
        end
    endtask

    px_t tbl[3];

    initial begin
        tbl[0] = '{3, 1'b0, 1'b0, 32'd0, 32'd0};
        tbl[1] = '{5, 1'b1, 1'b0, 32'd4, 32'd4};
        tbl[2] = '{2, 1'b0, 1'b1, 32'd8, 32'd0};

        // reset wins over start and done_window
        start = 1;
        done_window = 1;
        step;
        step;
        idle_chk("reset");
        start = 0;
        done_window = 0;
        reset_n = 1;
        step;
        idle_chk("idle");

        done_window = 1;
        step;
        done_window = 0;
        ovr = 1;
        idle_chk("idle_overrun");

        start = 1;
        step;
        start = 0;
        ovr = 0;
        for (int i = 0; i < 3; i++) run_pixel(tbl[i], i == 2);
        idle_chk("overrun_sticky");

        // new layer clears overrun, then reset lands in DRAIN k=2
        start = 1;
        step;
        start = 0;
        ovr = 0;
        cyc("conv2", 1, 0, 0, 0, 0, hw_a, hw_b, hr_a, hr_b, hwn, 0, 1, 0);
        done_window = 1;
        step;
        done_window = 0;
        cyc("fin2", 0, 1, 0, 0, 0, hw_a, hw_b, hr_a, hr_b, hwn, 0, 1, 0);
        step;
        for (int k = 0; k < 3; k++) begin
            cyc($sformatf("drain2_%0d", k), 0, 0, k == 0, 2'(k), 1, k, k, hr_a, hr_b, hwn, 0, 1, 0);
            if (k < 2) step;
        end
        reset_n = 0;
        step;
        reset_n = 1;
        hw_a = 0; hw_b = 0; hr_a = 0; hr_b = 0; hwn = 0;
        idle_chk("reset_mid_drain");
        step;
        idle_chk("reset_no_write");

        start = 1;
        step;
        start = 0;
        run_pixel('{1, 1'b0, 1'b0, 32'd0, 32'd0}, 1'b0);
        cyc("conv3", 1, 0, 0, 0, 0, hw_a, hw_b, hr_a, hr_b, hwn, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
